led_array_driver: RTL
=====================

LED_ARRAY_DRIVER -- requirements
Module: led_array_driver

Interface
REQ-001 SHALL have parameter N, default 8, number of board rows.
REQ-002 SHALL have parameter M, default 8, number of board columns.
REQ-003 SHALL have parameter BLANK_CYCLES, default 4, enabled cycles of all-off blanking before each row (legal range >= 1).
REQ-004 SHALL have parameter DWELL_CYCLES, default 1000, enabled cycles each row is driven (legal range >= 1).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ena  input  1  advance enable; when low, all internal state holds.
REQ-008 SHALL have port cells  input  N*M  board cell states; cell (r,c) is bit r*M+c.
REQ-009 SHALL have port rows  output  N  one-hot active-high row select.
REQ-010 SHALL have port cols  output  M  active-high column data for the selected row.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-012 SHALL implement a two-state FSM: BLANK and DRIVE, with a dwell counter and a row index 0..N-1.
REQ-013 SHALL size the counter to hold max(BLANK_CYCLES, DWELL_CYCLES)-1 and the row index to hold N-1, both with no overflow.
REQ-014 In BLANK, SHALL drive rows = 0 and cols = 0.
REQ-015 In DRIVE, SHALL drive rows = one-hot of row index, and cols[c] = snapshot bit (row*M + c).
REQ-016 SHALL decode rows/cols combinationally from registered state and snapshot, with no added latency.
REQ-017 SHALL capture cells into an internal N*M snapshot on any enabled cycle with state BLANK, row 0, counter 0.
REQ-018 SHALL display only snapshot contents, never live cells, so a frame shows no tearing.
REQ-019 On an enabled BLANK cycle with counter == BLANK_CYCLES-1, SHALL go to DRIVE and clear the counter; otherwise it SHALL increment the counter.
REQ-020 On an enabled DRIVE cycle with counter == DWELL_CYCLES-1, SHALL go to BLANK, clear the counter, and advance the row index; otherwise it SHALL increment the counter.
REQ-021 SHALL wrap the row index from N-1 to 0.
REQ-022 SHALL register frame_done high for exactly the one cycle after the row-N-1 DRIVE-to-BLANK transition; otherwise it SHALL be 0.
REQ-023 SHALL give a frame period of exactly N*(BLANK_CYCLES+DWELL_CYCLES) enabled cycles.
REQ-024 With ena low, SHALL hold state, counter, row index and snapshot, and SHALL hold rows/cols steady.
REQ-025 With ena low, SHALL drive frame_done 0 on the following cycle, so ena low never stretches a pulse.
REQ-026 SHALL NOT capture the snapshot while ena is low, even when in BLANK, row 0, counter 0.
REQ-027 SHALL ignore changes on cells between captures.

Reset
REQ-028 With rst high at a clock edge, SHALL set state = BLANK, counter = 0, row index = 0, snapshot = 0 and frame_done = 0, regardless of ena.
REQ-029 Reset values SHALL give rows = 0 and cols = 0 in the cycle after reset.
REQ-030 Reset asserted mid-row or mid-frame SHALL abort the scan with no frame_done pulse.
REQ-031 Reset priority SHALL be rst > ena.
REQ-032 On the first enabled cycle after reset release, SHALL capture the snapshot (BLANK, row 0, counter 0).

Verification
REQ-033 Bench SHALL run with N=2, M=3, BLANK_CYCLES=1, DWELL_CYCLES=2 and ena=1.
REQ-034 Basic scan: apply cells=6'b101_011, release rst -> rows/cols sequence per cycle is 00/000, 01/011, 01/011, 00/000, 10/101, 10/101, and frame_done=1 in the next cycle; repeats every 6 cycles.
REQ-035 Snapshot isolation: change cells to 6'b000_000 during row 0 DRIVE -> row 1 still shows cols=101; the next frame shows 000.
REQ-036 Hold: drop ena for 5 cycles during row 1 DRIVE -> rows=10 and cols=101 held throughout, frame_done stays 0; the scan resumes with the remaining dwell count intact.
REQ-037 Reset mid-frame: assert rst during row 1 DRIVE -> next cycle rows=00, cols=000, frame_done=0, no pulse; the scan restarts from row 0 with a fresh capture.
REQ-038 Wrap and pulse count: run 10 frames -> exactly 10 frame_done pulses, each one cycle wide, spaced 6 cycles apart; rows never non-one-hot while nonzero.

Source files
------------

// File: rtl/led_array_driver.sv
// Row-multiplexed LED array scanner: blanks, then drives each row of a
// frame-start snapshot of the board for a fixed dwell, emitting a frame pulse.
module led_array_driver #(
  parameter int unsigned N            = 8,
  parameter int unsigned M            = 8,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [N*M-1:0] cells,
  output logic [N-1:0]   rows,
  output logic [M-1:0]   cols,
  output logic           frame_done
);

  localparam int unsigned CNT_MAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned ROW_W   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [N*M-1:0]   snap_q, snap_d;
  logic             frame_done_d;

  // State register: FSM state, dwell counter, row index, snapshot, frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      row_q      <= '0;
      snap_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      snap_q     <= snap_d;
      frame_done <= frame_done_d;
    end
  end

  // Next-state logic; everything holds and the pulse drops while ena is low
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (ena) begin
      // Frame start: latch the whole board so the frame cannot tear
      if (state_q == BLANK && row_q == '0 && cnt_q == '0) begin
        snap_d = cells;
      end
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (row_q == ROW_LAST) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode straight from registered state, no extra pipeline stage
  always_comb begin
    rows = '0;
    cols = '0;
    if (state_q == DRIVE) begin
      rows = N'(1) << row_q;
      cols = M'(snap_q >> (row_q * M));
    end
  end

endmodule
